// File: rtl/compare_uart_loader.sv
// compare_uart_loader: loads the 24-bit compare value of the seven-segment
// seconds counter from a host over 8N1 UART.
// Frame: 0xA5, B2, B1, B0, CHK where CHK = B2^B1^B0 and value = {B2,B1,B0}.
// A zero value, a bad checksum, a bad stop bit or an inter-byte timeout
// each produce exactly one frame_error pulse.
//
// Receiver FSM
//   state     | meaning
//   R_IDLE    | line idle, waiting for rx_s low (start edge, t0)
//   R_START   | waiting for mid start bit; high there means false start
//   R_DATA    | sampling 8 data bits, LSB first, one bit period apart
//   R_STOP    | sampling stop bit; high = byte valid, low = framing error
//   R_WAIT    | framing error seen, waiting for the line to return high
//
// Parser FSM
//   state     | meaning
//   P_HUNT    | waiting for sync byte 0xA5, other bytes dropped silently
//   P_SYNC    | sync seen, next byte is B2
//   P_B2      | B2 stored, next byte is B1
//   P_B1      | B1 stored, next byte is B0
//   P_B0      | B0 stored, next byte is the checksum
module compare_uart_loader #(
    parameter int CLKS_PER_BIT = 139,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [23:0] compare_out,
    output logic        update_compare,
    output logic        frame_error,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [2:0] {P_HUNT, P_SYNC, P_B2, P_B1, P_B0} p_state_t;

    rx_state_t   rx_state;
    p_state_t    p_state;
    logic        rx_m, rx_s;
    logic [CW-1:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        stop_err;
    logic [TW-1:0] tmo_cnt;
    logic        timeout;
    logic [7:0]  b2, b1, b0;

    // Two-flop synchronizer for the asynchronous line, preset to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Byte receiver: mid-bit sampling via a down-counter reloaded every bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= R_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt  <= HALF_M1;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (bit_cnt == '0) begin
                        if (rx_s) begin
                            rx_state <= R_IDLE;
                        end else begin
                            bit_cnt  <= BIT_M1;
                            bit_idx  <= '0;
                            rx_state <= R_DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - C_ONE;
                    end
                end
                R_DATA: begin
                    if (bit_cnt == '0) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= BIT_M1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - C_ONE;
                    end
                end
                R_STOP: begin
                    if (bit_cnt == '0) begin
                        if (rx_s) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                            rx_state   <= R_IDLE;
                        end else begin
                            stop_err <= 1'b1;
                            rx_state <= R_WAIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - C_ONE;
                    end
                end
                R_WAIT: begin
                    if (rx_s) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Inter-byte timeout: counts only receiver-idle cycles inside a frame,
    // so it can never expire in the same cycle as a byte-valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= TMO_M1;
        end else if (byte_valid || p_state == P_HUNT) begin
            tmo_cnt <= TMO_M1;
        end else if (rx_state == R_IDLE && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - T_ONE;
        end
    end

    assign timeout = (p_state != P_HUNT) && (rx_state == R_IDLE) &&
                     (tmo_cnt == '0) && !byte_valid && !stop_err;

    // Frame parser: collects value bytes, validates, drives registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state        <= P_HUNT;
            b2             <= '0;
            b1             <= '0;
            b0             <= '0;
            compare_out    <= '0;
            update_compare <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            update_compare <= 1'b0;
            frame_error    <= 1'b0;
            if (stop_err) begin
                frame_error <= 1'b1;
                p_state     <= P_HUNT;
            end else if (byte_valid) begin
                case (p_state)
                    P_HUNT: if (rx_byte == 8'hA5) p_state <= P_SYNC;
                    P_SYNC: begin
                        b2      <= rx_byte;
                        p_state <= P_B2;
                    end
                    P_B2: begin
                        b1      <= rx_byte;
                        p_state <= P_B1;
                    end
                    P_B1: begin
                        b0      <= rx_byte;
                        p_state <= P_B0;
                    end
                    P_B0: begin
                        // Zero would stall the downstream counter, so it is rejected.
                        if (rx_byte == (b2 ^ b1 ^ b0) && {b2, b1, b0} != 24'd0) begin
                            compare_out    <= {b2, b1, b0};
                            update_compare <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        p_state <= P_HUNT;
                    end
                    default: p_state <= P_HUNT;
                endcase
            end else if (timeout) begin
                frame_error <= 1'b1;
                p_state     <= P_HUNT;
            end
        end
    end

    assign busy = (rx_state != R_IDLE) || (p_state != P_HUNT);

endmodule
